uart_echo_responder: RTL and testbench



---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_byte_fifo.sv | 47 ++++
 rtl/uart_echo_responder.sv | 137 +++++++++++++
 tb/tb_uart_echo_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared byte type, echo FSM states and default sizing for the UART echo responder
package uart_pkg;
  typedef logic [7:0] byte_t;
  typedef enum logic [1:0] {IDLE, REQ, BUSY, GAP} echo_state_t;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_REQ_TIMEOUT = 1024;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: circular first-word-fall-through byte FIFO; a push on full is taken only alongside a pop
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  byte_t                  din,
  output byte_t                  dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  byte_t mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    empty = count_q == '0;
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end
  assign dout = mem[rd_q];
  assign count = count_q;
endmodule

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: buffers error-free rx bytes and re-sends them over the tx handshake; UART_ECHO_STATS_EN adds rx/drop/tx counters
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int REQ_TIMEOUT = DEF_REQ_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_busy,
  input  logic                   rx_pkt_drop,
  output logic [7:0]             tx_data,
  output logic                   tx_wr_en,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   tx_timeout
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0]            rx_count,
  output logic [15:0]            drop_count,
  output logic [15:0]            tx_count
`endif
);
  localparam int TW = $clog2(max_int(GAP_CYCLES, REQ_TIMEOUT) + 1);
  logic rx_busy_q;
  logic byte_ev, push, pop, lost, fifo_full, fifo_empty;
  byte_t head;
  echo_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  byte_t tx_data_q, tx_data_d;
  logic tx_wr_en_q, tx_wr_en_d, overflow_q, overflow_d, tx_timeout_q, tx_timeout_d;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    byte_ev = rx_busy_q & ~rx_busy;
    push = byte_ev & ~rx_pkt_drop;
    pop = (state_q == REQ) & tx_busy;
    lost = push & fifo_full & ~pop;
    overflow_d = overflow_q | lost;
    state_d = state_q;
    timer_d = timer_q;
    tx_data_d = tx_data_q;
    tx_wr_en_d = tx_wr_en_q;
    tx_timeout_d = tx_timeout_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        tx_data_d = head;
        tx_wr_en_d = 1'b1;
        timer_d = '0;
        state_d = REQ;
      end
      REQ: if (tx_busy) begin
        tx_wr_en_d = 1'b0;
        state_d = BUSY;
      end else if (timer_q == TW'(REQ_TIMEOUT - 1)) begin
        // abandon the request but keep the head byte for the next attempt
        tx_wr_en_d = 1'b0;
        tx_timeout_d = 1'b1;
        timer_d = '0;
        state_d = GAP;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      BUSY: if (!tx_busy) begin
        timer_d = '0;
        state_d = GAP;
      end
      GAP: begin
        state_d = (timer_q == TW'(GAP_CYCLES - 1)) ? IDLE : GAP;
        timer_d = (timer_q == TW'(GAP_CYCLES - 1)) ? timer_q : timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy_q <= 1'b0;
      state_q <= IDLE;
      timer_q <= '0;
      tx_data_q <= '0;
      tx_wr_en_q <= 1'b0;
      overflow_q <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      rx_busy_q <= rx_busy;
      state_q <= state_d;
      timer_q <= timer_d;
      tx_data_q <= tx_data_d;
      tx_wr_en_q <= tx_wr_en_d;
      overflow_q <= overflow_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_wr_en = tx_wr_en_q;
  assign overflow = overflow_q;
  assign tx_timeout = tx_timeout_q;

`ifdef UART_ECHO_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d, tx_cnt_q, tx_cnt_d;
  always_comb begin
    rx_cnt_d = (push & ~lost & ~&rx_cnt_q) ? rx_cnt_q + 1'b1 : rx_cnt_q;
    drop_cnt_d = (((byte_ev & rx_pkt_drop) | lost) & ~&drop_cnt_q) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    tx_cnt_d = (pop & ~&tx_cnt_q) ? tx_cnt_q + 1'b1 : tx_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q <= '0;
      drop_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end
  assign rx_count = rx_cnt_q;
  assign drop_count = drop_cnt_q;
  assign tx_count = tx_cnt_q;
`endif
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: table-driven, directed and randomized checks against a queue-based echo model
module tb_uart_echo_responder;
  import uart_pkg::*;
  localparam int DEPTH = 8;
  localparam int GAP = 16;
  localparam int TMO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_busy = 1'b0;
  logic rx_pkt_drop = 1'b0;
  logic tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic tx_wr_en;
  logic [$clog2(DEPTH):0] fifo_count;
  logic overflow, tx_timeout;
`ifdef UART_ECHO_STATS_EN
  logic [15:0] rx_count, drop_count, tx_count;
`endif

  always #5 clk = ~clk;

  uart_echo_responder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .REQ_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_busy     (rx_busy),
    .rx_pkt_drop (rx_pkt_drop),
    .tx_data     (tx_data),
    .tx_wr_en    (tx_wr_en),
    .tx_busy     (tx_busy),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .tx_timeout  (tx_timeout)
`ifdef UART_ECHO_STATS_EN
    ,
    .rx_count    (rx_count),
    .drop_count  (drop_count),
    .tx_count    (tx_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  byte_t q[$];
  byte_t elog[$];
  logic m_ovf = 0, m_to = 0, m_rxq = 0, prev_wr = 0, prev_busy = 0, acc_seen = 0;
  byte_t prev_data = '0, last_echo = '0;
  int edge_n = 0, fall_edge = -1000, to_edge = -1000, last_rise = -1000, run_len = 0;
  int n_echo = 0, n_rise = 0, m_rx = 0, m_drop = 0, m_tx = 0;
  int tx_mode = 0, tx_lat = 2, tx_len = 3, lat_cnt = 0, len_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_to = 0; m_rxq = 0; prev_wr = 0; prev_data = '0; acc_seen = 0;
    prev_busy = tx_busy;
    fall_edge = -1000; to_edge = -1000; run_len = 0;
    m_rx = 0; m_drop = 0; m_tx = 0;
  endtask

  // Runs once per clock, on the falling edge, applying that edge's inputs to the reference model
  task automatic observe();
    int sz0;
    logic acc, ev;
    edge_n++;
    if (rst) begin
      model_reset();
      chk("rst_wr_en", tx_wr_en, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_timeout", tx_timeout, 0);
      chk("rst_tx_data", tx_data, 0);
      return;
    end
    sz0 = q.size();
    acc = prev_wr && tx_busy;
    ev = m_rxq && !rx_busy;
    m_rxq = rx_busy;
    if (acc) begin
      chk("pop_nonempty", sz0 != 0, 1);
      if (sz0 != 0) begin
        chk("echo_byte", prev_data, q[0]);
        void'(q.pop_front());
      end
      last_echo = prev_data;
      elog.push_back(prev_data);
      n_echo++; m_tx++; acc_seen = 1;
      chk("wr_drop_after_busy", tx_wr_en, 0);
    end
    if (ev) begin
      if (rx_pkt_drop) m_drop++;
      else if (q.size() < DEPTH) begin
        q.push_back(rx_data);
        m_rx++;
      end else begin
        m_ovf = 1;
        m_drop++;
      end
    end
    if (!prev_wr && tx_wr_en) begin
      n_rise++;
      last_rise = edge_n;
      chk("req_nonempty", sz0 != 0, 1);
      if (sz0 != 0) chk("req_data", tx_data, q[0]);
      chk("gap_after_busy", (edge_n - fall_edge) >= GAP + 1, 1);
      chk("gap_after_timeout", (edge_n - to_edge) >= GAP + 1, 1);
      run_len = 0;
    end
    if (prev_wr && tx_wr_en) chk("data_stable", tx_data, prev_data);
    if (tx_wr_en) run_len++;
    if (prev_wr && !tx_wr_en && !acc) begin
      chk("timeout_len", run_len, TMO);
      m_to = 1;
      to_edge = edge_n;
    end
    if (!tx_wr_en) run_len = 0;
    if (prev_busy && !tx_busy && acc_seen) begin
      fall_edge = edge_n;
      acc_seen = 0;
    end
    prev_busy = tx_busy;
    prev_wr = tx_wr_en;
    prev_data = tx_data;
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("tx_timeout", tx_timeout, m_to);
  endtask

  // Transmitter model: 0 = responds after tx_lat clocks for tx_len clocks, 1 = never busy, 2 = driven by hand
  task automatic tx_model();
    if (tx_mode == 1) tx_busy = 0;
    else if (tx_mode == 0) begin
      if (tx_busy) begin
        len_cnt++;
        if (len_cnt >= tx_len) tx_busy = 0;
      end else if (tx_wr_en) begin
        lat_cnt++;
        if (lat_cnt >= tx_lat) begin
          tx_busy = 1; lat_cnt = 0; len_cnt = 0;
        end
      end else lat_cnt = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    tx_model();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send(input byte_t d, input logic drop, input logic busy_now);
    rx_busy = 1;
    repeat (3) step();
    rx_busy = 0; rx_data = d; rx_pkt_drop = drop;
    if (busy_now) tx_busy = 1;
    step();
    rx_pkt_drop = 0;
  endtask

  task automatic drain(input string nm, input int bound);
    for (int t = 0; t < bound && (fifo_count != 0 || tx_wr_en); t++) step();
    run(40);
    chk(nm, fifo_count, 0);
  endtask

  typedef struct {
    byte_t d;
    logic  drop;
    int    lat;
    int    len;
    int    exp_n;
    byte_t exp_b;
  } vec_t;

  vec_t tbl[6];
  byte_t burst[5];
  int n0, r0;

  initial begin
    tbl[0] = '{8'h55, 1'b0, 2, 3, 1, 8'h55};
    tbl[1] = '{8'hA5, 1'b1, 2, 3, 0, 8'h00};
    tbl[2] = '{8'h00, 1'b0, 1, 1, 1, 8'h00};
    tbl[3] = '{8'hFF, 1'b0, 0, 5, 1, 8'hFF};
    tbl[4] = '{8'h3C, 1'b0, 4, 2, 1, 8'h3C};
    tbl[5] = '{8'h81, 1'b1, 1, 1, 0, 8'h00};
    burst = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h1E};
    model_reset();
    rst = 1; run(2); rst = 0; run(2);

    tx_mode = 0; tx_lat = 2; tx_len = 3;
    send(8'h55, 0, 0);
    step(); chk("single_wr_rise", tx_wr_en, 1); chk("single_data", tx_data, 8'h55);
    step(); chk("single_wr_hold", tx_wr_en, 1);
    step(); chk("single_wr_drop", tx_wr_en, 0); chk("single_popped", fifo_count, 0);
    send(8'hAA, 0, 0);
    r0 = n_rise;
    for (int t = 0; t < 60 && n_rise == r0; t++) step();
    chk("gap_exact", last_rise - fall_edge, GAP + 1);
    run(40);

    for (int i = 0; i < 6; i++) begin
      tx_mode = 0; tx_lat = tbl[i].lat; tx_len = tbl[i].len;
      n0 = n_echo;
      send(tbl[i].d, tbl[i].drop, 0);
      run(60);
      chk("vec_echo_n", n_echo - n0, tbl[i].exp_n);
      if (tbl[i].exp_n != 0) chk("vec_echo_byte", last_echo, tbl[i].exp_b);
      chk("vec_idle_count", fifo_count, 0);
    end

    tx_lat = 1; tx_len = 200; n0 = n_echo;
    send(burst[0], 0, 0);
    for (int t = 0; t < 20 && n_echo == n0; t++) step();
    chk("burst_first_accept", n_echo - n0, 1);
    for (int i = 1; i < 5; i++) send(burst[i], 0, 0);
    chk("burst_peak", fifo_count, 4);
    chk("burst_overflow", overflow, 0);
    tx_len = 3;
    drain("burst_drain", 400);
    chk("burst_n", n_echo - n0, 5);
    for (int k = 0; k < 5; k++) chk("burst_order", elog[elog.size() - 5 + k], burst[k]);

    rst = 1; step(); rst = 0;
    tx_mode = 1;
    for (int i = 0; i < DEPTH + 2; i++) send(8'h10 + 8'(i), 0, 0);
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_wr", tx_wr_en, 1);
    for (int t = 0; t < TMO + 50 && !tx_timeout; t++) step();
    chk("to_flag", tx_timeout, 1);
    chk("to_head", tx_data, 8'h10);
    chk("to_count", fifo_count, DEPTH);
    chk("to_wr", tx_wr_en, 0);
    tx_mode = 0; tx_lat = 1; tx_len = 2;
    drain("ovf_drain", 600);
    chk("ovf_last", last_echo, 8'h17);

    rst = 1; step(); rst = 0;
    tx_mode = 2; tx_busy = 0; n0 = n_echo;
    for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i), 0, 0);
    chk("full_count", fifo_count, DEPTH);
    chk("full_wr", tx_wr_en, 1);
    send(8'h4F, 0, 1);
    chk("full_pp_count", fifo_count, DEPTH);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_wr", tx_wr_en, 0);
    tx_busy = 0; tx_mode = 0; tx_lat = 1; tx_len = 2;
    drain("full_drain", 600);
    chk("full_n", n_echo - n0, DEPTH + 1);
    chk("full_last", last_echo, 8'h4F);

    rst = 1; step(); rst = 0;
    tx_mode = 1;
    for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 0, 0);
    chk("mid_wr", tx_wr_en, 1);
    chk("mid_count", fifo_count, 3);
    rst = 1; step(); rst = 0;
    chk("mid_rst_wr", tx_wr_en, 0);
    r0 = n_rise;
    run(40);
    chk("mid_no_req", n_rise - r0, 0);
    chk("mid_count_after", fifo_count, 0);

    tx_mode = 2; tx_busy = 1; run(2); n0 = n_echo;
    send(8'h77, 0, 0);
    step(); chk("prebusy_rise", tx_wr_en, 1);
    step(); chk("prebusy_drop", tx_wr_en, 0);
    chk("prebusy_n", n_echo - n0, 1);
    chk("prebusy_byte", last_echo, 8'h77);
    tx_busy = 0; tx_mode = 0; run(40);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tx_lat = int'($urandom_range(0, 4));
        tx_len = int'($urandom_range(1, 30));
      end
      send(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0, 0);
      run(int'($urandom_range(0, 40)));
    end
    drain("rand_drain", 3000);

`ifdef UART_ECHO_STATS_EN
    chk("stat_rx", rx_count, m_rx);
    chk("stat_drop", drop_count, m_drop);
    chk("stat_tx", tx_count, m_tx);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
